// File: rtl/inst_queue_if.sv
// ============================================================
// inst_queue_if : fetch/decode side signals of the instruction queue
// Rev 1.0
// ============================================================
`default_nettype none

interface inst_queue_if #(
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);

  logic        flush;
  logic        in_valid0;
  logic        in_valid1;
  logic [31:0] in_pc0;
  logic [31:0] in_inst0;
  logic [31:0] in_pc1;
  logic [31:0] in_inst1;
  logic        in_ready;
  logic        dec_stall;
  logic        only_one;
  logic        out_valid0;
  logic [31:0] out_pc0;
  logic [31:0] out_inst0;
  logic        out_valid1;
  logic [31:0] out_pc1;
  logic [31:0] out_inst1;
  logic [AW:0] count;

  modport master (
    output flush, in_valid0, in_valid1, in_pc0, in_inst0, in_pc1, in_inst1,
    output dec_stall, only_one,
    input  in_ready, out_valid0, out_pc0, out_inst0,
    input  out_valid1, out_pc1, out_inst1, count
  );

  modport slave (
    input  flush, in_valid0, in_valid1, in_pc0, in_inst0, in_pc1, in_inst1,
    input  dec_stall, only_one,
    output in_ready, out_valid0, out_pc0, out_inst0,
    output out_valid1, out_pc1, out_inst1, count
  );
endinterface

`default_nettype wire

// File: rtl/inst_queue.sv
// ============================================================
// inst_queue : dual-ported fetch-to-decode instruction FIFO
// Rev 1.0
// ============================================================
`default_nettype none

module inst_queue #(
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         resetn,
  inst_queue_if.slave  q
);
  localparam int          AW         = $clog2(DEPTH);
  localparam logic [AW:0] C_MAX_FILL = (AW+1)'(DEPTH - 2);
  localparam logic [AW:0] C_TWO      = (AW+1)'(2);

  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [AW:0]   count_q, count_d;

  logic [31:0]   pc_mem_q   [DEPTH];
  logic [31:0]   inst_mem_q [DEPTH];

  logic          ready_w;
  logic          valid0_w;
  logic          valid1_w;
  logic          push0_w;
  logic          push1_w;
  logic [1:0]    n_push_w;
  logic [1:0]    n_pop_w;
  logic [AW-1:0] head1_w;
  logic [AW-1:0] tail1_w;

  always_comb begin
    ready_w  = (count_q <= C_MAX_FILL);
    valid0_w = (count_q != '0);
    valid1_w = (count_q >= C_TWO);
    head1_w  = head_q + 1'b1;
    tail1_w  = tail_q + 1'b1;

    // A lone in_valid1 is illegal and is ignored.
    push0_w  = ready_w & ~q.flush & q.in_valid0;
    push1_w  = push0_w & q.in_valid1;
    n_push_w = {1'b0, push0_w} + {1'b0, push1_w};

    n_pop_w = 2'd0;
    if (!q.dec_stall && !q.flush && valid0_w) begin
      n_pop_w = (q.only_one || !valid1_w) ? 2'd1 : 2'd2;
    end

    if (q.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + AW'(n_pop_w);
      tail_d  = tail_q + AW'(n_push_w);
      count_d = count_q + (AW+1)'(n_push_w) - (AW+1)'(n_pop_w);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is intentionally left unreset; validity comes from count_q.
  always_ff @(posedge clk) begin
    if (push0_w) begin
      pc_mem_q[tail_q]   <= q.in_pc0;
      inst_mem_q[tail_q] <= q.in_inst0;
    end
    if (push1_w) begin
      pc_mem_q[tail1_w]   <= q.in_pc1;
      inst_mem_q[tail1_w] <= q.in_inst1;
    end
  end

  assign q.in_ready   = ready_w;
  assign q.count      = count_q;
  assign q.out_valid0 = valid0_w;
  assign q.out_valid1 = valid1_w;
  assign q.out_pc0    = valid0_w ? pc_mem_q[head_q]    : 32'h0;
  assign q.out_inst0  = valid0_w ? inst_mem_q[head_q]  : 32'h0;
  assign q.out_pc1    = valid1_w ? pc_mem_q[head1_w]   : 32'h0;
  assign q.out_inst1  = valid1_w ? inst_mem_q[head1_w] : 32'h0;

endmodule

`default_nettype wire

// File: tb/tb_inst_queue.sv
// ============================================================
// tb_inst_queue : scoreboard bench for inst_queue
// Rev 1.0
// ============================================================
`default_nettype none

module tb_inst_queue;
  localparam int DEPTH = 16;

  logic clk;
  logic resetn;
  int   total;
  int   bad;
  logic [63:0] sb[$];

  inst_queue_if #(.DEPTH(DEPTH)) qif ();

  inst_queue #(.DEPTH(DEPTH)) dut (
    .clk    (clk),
    .resetn (resetn),
    .q      (qif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'h2408_5a5a;
  endfunction

  task automatic idle_inputs();
    qif.flush     = 1'b0;
    qif.in_valid0 = 1'b0;
    qif.in_valid1 = 1'b0;
    qif.in_pc0    = 32'h0;
    qif.in_inst0  = 32'h0;
    qif.in_pc1    = 32'h0;
    qif.in_inst1  = 32'h0;
    qif.dec_stall = 1'b0;
    qif.only_one  = 1'b0;
  endtask

  // Called at a negedge: drives one cycle, updates the reference queue, returns at the next negedge.
  task automatic drive_cycle(input logic v0, input logic v1,
                             input logic [31:0] pc0, input logic [31:0] i0,
                             input logic [31:0] pc1, input logic [31:0] i1,
                             input logic stall, input logic one, input logic fl);
    bit rdy;
    int n;
    qif.in_valid0 = v0;
    qif.in_valid1 = v1;
    qif.in_pc0    = pc0;
    qif.in_inst0  = i0;
    qif.in_pc1    = pc1;
    qif.in_inst1  = i1;
    qif.dec_stall = stall;
    qif.only_one  = one;
    qif.flush     = fl;
    rdy = ((DEPTH - sb.size()) >= 2);
    n = 0;
    if (!stall && !fl && sb.size() >= 1) n = (one || sb.size() < 2) ? 1 : 2;
    @(posedge clk);
    if (fl) begin
      sb.delete();
    end else begin
      for (int k = 0; k < n; k++) void'(sb.pop_front());
      if (rdy && v0) begin
        sb.push_back({pc0, i0});
        if (v1) sb.push_back({pc1, i1});
      end
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic push_pair(input logic [31:0] pc);
    drive_cycle(1'b1, 1'b1, pc, inst_of(pc), pc + 32'd4, inst_of(pc + 32'd4), 1'b1, 1'b0, 1'b0);
  endtask

  task automatic push_one(input logic [31:0] pc, input logic stall);
    drive_cycle(1'b1, 1'b0, pc, inst_of(pc), 32'h0, 32'h0, stall, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int k = 0; k < 2 * DEPTH && sb.size() > 0; k++)
      drive_cycle(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    #2;
    total++;
    if (qif.out_valid0 !== 1'b0 || qif.out_valid1 !== 1'b0) begin
      bad++; $display("FAIL reset_valid got=%b%b exp=00", qif.out_valid0, qif.out_valid1);
    end
    total++;
    if (qif.count !== 5'd0 || qif.in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_count got=%0d/%b exp=0/1", qif.count, qif.in_ready);
    end
    @(negedge clk);
    resetn = 1'b1;
    push_pair(32'hbfc0_0200);
    push_pair(32'hbfc0_0208);
    push_one(32'hbfc0_0210, 1'b1);
    total++;
    if (qif.count !== 5'd5) begin
      bad++; $display("FAIL pre_reset_count got=%0d exp=5", qif.count);
    end
    resetn = 1'b0;
    #1;
    total++;
    if (qif.out_valid0 !== 1'b0 || qif.out_valid1 !== 1'b0) begin
      bad++; $display("FAIL midrun_reset_valid got=%b%b exp=00", qif.out_valid0, qif.out_valid1);
    end
    total++;
    if (qif.count !== 5'd0 || qif.in_ready !== 1'b1) begin
      bad++; $display("FAIL midrun_reset_count got=%0d/%b exp=0/1", qif.count, qif.in_ready);
    end
    sb.delete();
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_dual();
    drive_cycle(1'b1, 1'b1, 32'hbfc0_0000, 32'h2408_0001, 32'hbfc0_0004, 32'h2409_0002,
                1'b0, 1'b0, 1'b0);
    total++;
    if (qif.out_pc0 !== 32'hbfc0_0000 || qif.out_pc1 !== 32'hbfc0_0004) begin
      bad++; $display("FAIL dual_pcs got=%h,%h exp=bfc00000,bfc00004", qif.out_pc0, qif.out_pc1);
    end
    total++;
    if (qif.out_inst0 !== 32'h2408_0001 || qif.out_inst1 !== 32'h2409_0002) begin
      bad++; $display("FAIL dual_insts got=%h,%h exp=24080001,24090002", qif.out_inst0, qif.out_inst1);
    end
    total++;
    if (qif.count !== 5'd2 || qif.out_valid1 !== 1'b1) begin
      bad++; $display("FAIL dual_count got=%0d/%b exp=2/1", qif.count, qif.out_valid1);
    end
    drive_cycle(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    total++;
    if (qif.count !== 5'd0 || qif.out_valid0 !== 1'b0 || qif.out_pc0 !== 32'h0) begin
      bad++; $display("FAIL dual_pop got=%0d/%b/%h exp=0/0/0", qif.count, qif.out_valid0, qif.out_pc0);
    end
  endtask

  task automatic test_single_issue();
    push_pair(32'hbfc0_0300);
    push_one(32'hbfc0_0308, 1'b1);
    total++;
    if (qif.count !== 5'd3 || qif.out_pc0 !== 32'hbfc0_0300) begin
      bad++; $display("FAIL single_pre got=%0d/%h exp=3/bfc00300", qif.count, qif.out_pc0);
    end
    drive_cycle(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    total++;
    if (qif.count !== 5'd2) begin
      bad++; $display("FAIL single_count got=%0d exp=2", qif.count);
    end
    total++;
    if (qif.out_pc0 !== 32'hbfc0_0304 || qif.out_pc1 !== 32'hbfc0_0308) begin
      bad++; $display("FAIL single_pcs got=%h,%h exp=bfc00304,bfc00308", qif.out_pc0, qif.out_pc1);
    end
    total++;
    if (qif.out_inst1 !== sb[1][31:0]) begin
      bad++; $display("FAIL single_inst1 got=%h exp=%h", qif.out_inst1, sb[1][31:0]);
    end
    drain();
  endtask

  task automatic test_full_wrap();
    logic [31:0] next_pc;
    bit          rdy;
    next_pc = 32'hbfc0_1000;
    push_one(next_pc, 1'b1);
    next_pc += 32'd4;
    for (int k = 0; k < 8 && sb.size() < 15; k++) begin
      push_pair(next_pc);
      next_pc += 32'd8;
    end
    total++;
    if (qif.count !== 5'd15 || qif.in_ready !== 1'b0) begin
      bad++; $display("FAIL full_ready got=%0d/%b exp=15/0", qif.count, qif.in_ready);
    end
    for (int k = 0; k < 2; k++) begin
      push_pair(next_pc);
      total++;
      if (qif.count !== 5'd15) begin
        bad++; $display("FAIL full_hold got=%0d exp=15", qif.count);
      end
    end
    for (int c = 0; c < 40; c++) begin
      total++;
      if (qif.out_pc0 !== sb[0][63:32] || qif.out_inst0 !== sb[0][31:0]) begin
        bad++; $display("FAIL stream_slot0 c=%0d got=%h exp=%h", c, qif.out_pc0, sb[0][63:32]);
      end
      total++;
      if (qif.out_pc1 !== sb[1][63:32] || qif.out_pc1 !== qif.out_pc0 + 32'd4) begin
        bad++; $display("FAIL stream_slot1 c=%0d got=%h exp=%h", c, qif.out_pc1, sb[1][63:32]);
      end
      rdy = (sb.size() <= DEPTH - 2);
      drive_cycle(1'b1, 1'b1, next_pc, inst_of(next_pc), next_pc + 32'd4, inst_of(next_pc + 32'd4),
                  1'b0, 1'b0, 1'b0);
      if (rdy) next_pc += 32'd8;
      total++;
      if (qif.count !== 5'(sb.size())) begin
        bad++; $display("FAIL stream_count c=%0d got=%0d exp=%0d", c, qif.count, sb.size());
      end
    end
    for (int k = 0; k < 2 * DEPTH && sb.size() > 0; k++) begin
      total++;
      if (qif.out_pc0 !== sb[0][63:32]) begin
        bad++; $display("FAIL drain_order got=%h exp=%h", qif.out_pc0, sb[0][63:32]);
      end
      drive_cycle(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    end
    total++;
    if (qif.count !== 5'd0 || qif.out_valid0 !== 1'b0) begin
      bad++; $display("FAIL drain_empty got=%0d/%b exp=0/0", qif.count, qif.out_valid0);
    end
  endtask

  task automatic test_stall();
    push_pair(32'hbfc0_2000);
    push_pair(32'hbfc0_2008);
    for (int c = 0; c < 4; c++) begin
      if (c < 2) drive_cycle(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
      else       push_pair(32'hbfc0_2010 + 32'(8 * (c - 2)));
      total++;
      if (qif.out_pc0 !== 32'hbfc0_2000 || qif.out_pc1 !== 32'hbfc0_2004) begin
        bad++; $display("FAIL stall_stable c=%0d got=%h,%h exp=bfc02000,bfc02004", c, qif.out_pc0, qif.out_pc1);
      end
      total++;
      if (qif.count !== ((c < 2) ? 5'd4 : 5'(4 + 2 * (c - 1)))) begin
        bad++; $display("FAIL stall_count c=%0d got=%0d exp=%0d", c, qif.count, sb.size());
      end
    end
    drain();
  endtask

  task automatic test_flush();
    push_pair(32'hbfc0_3000);
    push_pair(32'hbfc0_3008);
    push_pair(32'hbfc0_3010);
    total++;
    if (qif.count !== 5'd6) begin
      bad++; $display("FAIL flush_pre got=%0d exp=6", qif.count);
    end
    drive_cycle(1'b1, 1'b1, 32'hbfc0_3018, 32'h1, 32'hbfc0_301c, 32'h2, 1'b0, 1'b0, 1'b1);
    total++;
    if (qif.count !== 5'd0 || qif.out_valid0 !== 1'b0 || qif.in_ready !== 1'b1) begin
      bad++; $display("FAIL flush_empty got=%0d/%b/%b exp=0/0/1", qif.count, qif.out_valid0, qif.in_ready);
    end
    push_one(32'hbfc0_0100, 1'b0);
    total++;
    if (qif.out_valid0 !== 1'b1 || qif.out_pc0 !== 32'hbfc0_0100 || qif.count !== 5'd1) begin
      bad++; $display("FAIL flush_refill got=%b/%h/%0d exp=1/bfc00100/1", qif.out_valid0, qif.out_pc0, qif.count);
    end
    total++;
    if (qif.out_inst0 !== inst_of(32'hbfc0_0100) || qif.out_valid1 !== 1'b0) begin
      bad++; $display("FAIL flush_refill_inst got=%h/%b exp=%h/0", qif.out_inst0, qif.out_valid1, inst_of(32'hbfc0_0100));
    end
    drain();
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    resetn = 1'b0;
    idle_inputs();
    test_reset();
    test_dual();
    test_single_issue();
    test_full_wrap();
    test_stall();
    test_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
